// File: rtl/mnist_pkg.sv
// Shared constants and state encoding for the MNIST vector-matrix-product sequencer.
package mnist_pkg;

    localparam int N_PIXELS       = 784;
    localparam int PIX_W          = 10;
    localparam int N_CLASSES      = 10;
    localparam int RES_W          = 26;   // signed 8.18 score
    localparam int WEIGHT_W       = 19;
    localparam int RES_FRAC       = 18;
    localparam int WEIGHT_FRAC    = 16;
    localparam int START_CYCLES   = 2;
    localparam int COMPUTE_CYCLES = 290;

    localparam int ID_W      = 4;
    localparam int PIX_CNT_W = $clog2(N_PIXELS);
    localparam int CYC_MAX   = (START_CYCLES > COMPUTE_CYCLES) ? START_CYCLES : COMPUTE_CYCLES;
    localparam int CYC_W     = $clog2(CYC_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_COMPUTE = 3'd3,
        S_ARGMAX  = 3'd4,
        S_DONE    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/vmp_argmax_scan.sv
// Serial signed argmax: one score per cycle, first seeds, strictly-greater replaces.
module vmp_argmax_scan
    import mnist_pkg::*;
(
    input  logic             clk,
    input  logic             rst_i,
    input  logic             first_i,
    input  logic             valid_i,
    input  logic [RES_W-1:0] score_i,
    input  logic [ID_W-1:0]  index_i,
    output logic [ID_W-1:0]  best_id_o,
    output logic [RES_W-1:0] best_score_o
);

    logic [ID_W-1:0]  best_id_q,    best_id_d;
    logic [RES_W-1:0] best_score_q, best_score_d;

    // Next best: take the incoming score on the seed, or when it strictly beats the best so far.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        best_id_d    = best_id_q;
        best_score_d = best_score_q;
        if (valid_i && (first_i || ($signed(score_i) > $signed(best_score_q)))) begin
            best_id_d    = index_i;
            best_score_d = score_i;
        end
    end

    // Best-so-far registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst_i) begin
            best_id_q    <= '0;
            best_score_q <= '0;
        end else begin
            best_id_q    <= best_id_d;
            best_score_q <= best_score_d;
        end
    end

    assign best_id_o    = best_id_q;
    assign best_score_o = best_score_q;

endmodule

// File: rtl/mnist_vmp_sequencer.sv
// Sequences one inference: pixel stream -> packed Pixels bus -> VMP start/compute -> argmax -> result handshake.
module mnist_vmp_sequencer
    import mnist_pkg::*;
(
    input  logic                          clk,
    input  logic                          GlobalReset,
    input  logic                          pix_valid,
    input  logic [PIX_W-1:0]              pix_data,
    input  logic                          pix_last,
    output logic                          pix_ready,
    output logic [N_PIXELS*PIX_W-1:0]     Pixels,
    output logic                          vmp_start,
    input  logic [N_CLASSES*RES_W-1:0]    vmp_value,
    output logic                          class_valid,
    input  logic                          class_ready,
    output logic [ID_W-1:0]               class_id,
    output logic [RES_W-1:0]              class_score,
    output logic                          busy,
    output logic                          frame_err
);

    seq_state_e             state_q, state_d;
    logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [CYC_W-1:0]       cyc_cnt_q, cyc_cnt_d;
    logic [ID_W-1:0]        class_id_q, class_id_d;
    logic [RES_W-1:0]       class_score_q, class_score_d;
    logic                   frame_err_q, frame_err_d;
    logic [N_PIXELS*PIX_W-1:0] pixels_q;

    logic                   accept;
    logic                   pix_we;
    logic [PIX_CNT_W-1:0]   pix_idx;
    logic                   scan_valid;
    logic                   scan_first;
    logic [RES_W-1:0]       scan_score;
    logic [ID_W-1:0]        scan_best_id;
    logic [RES_W-1:0]       scan_best_score;

    assign accept = pix_valid && pix_ready;

    // Next-state, counters, pixel write strobe and scan feed.
    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        cyc_cnt_d     = cyc_cnt_q;
        class_id_d    = class_id_q;
        class_score_d = class_score_q;
        frame_err_d   = 1'b0;
        pix_we        = 1'b0;
        pix_idx       = pix_cnt_q;
        scan_valid    = 1'b0;
        scan_first    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pix_we    = 1'b1;
                    pix_idx   = '0;
                    pix_cnt_d = PIX_CNT_W'(1);
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    pix_we = 1'b1;
                    if (pix_cnt_q == PIX_CNT_W'(N_PIXELS - 1)) begin
                        pix_cnt_d = '0;
                        if (pix_last) begin
                            cyc_cnt_d = '0;
                            state_d   = S_START;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end else if (pix_last) begin
                        pix_cnt_d   = '0;
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
                    end
                end
            end
            S_START: begin
                if (cyc_cnt_q == CYC_W'(START_CYCLES - 1)) begin
                    cyc_cnt_d = '0;
                    state_d   = S_COMPUTE;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
                end
            end
            S_COMPUTE: begin
                if (cyc_cnt_q == CYC_W'(COMPUTE_CYCLES - 1)) begin
                    cyc_cnt_d = '0;
                    state_d   = S_ARGMAX;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
                end
            end
            S_ARGMAX: begin
                // Counts 0..N_CLASSES-1 feed the scan; the extra cycle latches its settled result.
                if (cyc_cnt_q < CYC_W'(N_CLASSES)) begin
                    scan_valid = 1'b1;
                    scan_first = (cyc_cnt_q == '0);
                    cyc_cnt_d  = cyc_cnt_q + CYC_W'(1);
                end else begin
                    class_id_d    = scan_best_id;
                    class_score_d = scan_best_score;
                    cyc_cnt_d     = '0;
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                if (class_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Select the score of the class currently being scanned.
    always_comb begin
        scan_score = '0;
        for (int c = 0; c < N_CLASSES; c++) begin
            if (cyc_cnt_q == CYC_W'(c)) begin
                scan_score = vmp_value[c*RES_W +: RES_W];
            end
        end
    end

    // State, counters and result registers.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q       <= S_IDLE;
            pix_cnt_q     <= '0;
            cyc_cnt_q     <= '0;
            class_id_q    <= '0;
            class_score_q <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            cyc_cnt_q     <= cyc_cnt_d;
            class_id_q    <= class_id_d;
            class_score_q <= class_score_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Pixel image store; written only while loading, so it is stable from START through DONE.
    always_ff @(posedge clk) begin
        // NOTE: this storage is reset because the Pixels bus must read zero out of reset.
        if (GlobalReset) begin
            pixels_q <= '0;
        end else if (pix_we) begin
            pixels_q[pix_idx*PIX_W +: PIX_W] <= pix_data;
        end
    end

    vmp_argmax_scan u_scan (
        .clk          (clk),
        .rst_i        (GlobalReset),
        .first_i      (scan_first),
        .valid_i      (scan_valid),
        .score_i      (scan_score),
        .index_i      (cyc_cnt_q[ID_W-1:0]),
        .best_id_o    (scan_best_id),
        .best_score_o (scan_best_score)
    );

    // The VMP is held in reset whenever the sequencer is, and during the launch window.
    assign vmp_start   = GlobalReset || (state_q == S_START);
    assign pix_ready   = !GlobalReset && ((state_q == S_IDLE) || (state_q == S_LOAD));
    assign busy        = !GlobalReset && (state_q != S_IDLE);
    assign class_valid = !GlobalReset && (state_q == S_DONE);
    assign class_id    = class_id_q;
    assign class_score = class_score_q;
    assign frame_err   = frame_err_q;
    assign Pixels      = pixels_q;

endmodule

// File: tb/tb_mnist_vmp_sequencer.sv
// Self-checking bench for mnist_vmp_sequencer with a behavioural VMP model and argmax reference.
module tb_mnist_vmp_sequencer;
    import mnist_pkg::*;

    localparam int LAT = START_CYCLES + COMPUTE_CYCLES + N_CLASSES + 1;

    logic                       clk = 1'b0;
    logic                       GlobalReset;
    logic                       pix_valid;
    logic [PIX_W-1:0]           pix_data;
    logic                       pix_last;
    logic                       pix_ready;
    logic [N_PIXELS*PIX_W-1:0]  Pixels;
    logic                       vmp_start;
    logic [N_CLASSES*RES_W-1:0] vmp_value;
    logic                       class_valid;
    logic                       class_ready;
    logic [ID_W-1:0]            class_id;
    logic [RES_W-1:0]           class_score;
    logic                       busy;
    logic                       frame_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [PIX_W-1:0]           img [N_PIXELS];
    logic [N_PIXELS*PIX_W-1:0]  exp_pix;
    bit                         half_mode;
    logic [N_CLASSES*RES_W-1:0] model_scores;
    int                         vmp_cnt = COMPUTE_CYCLES;

    mnist_vmp_sequencer dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_last    (pix_last),
        .pix_ready   (pix_ready),
        .Pixels      (Pixels),
        .vmp_start   (vmp_start),
        .vmp_value   (vmp_value),
        .class_valid (class_valid),
        .class_ready (class_ready),
        .class_id    (class_id),
        .class_score (class_score),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // VMP with every weight 0.5: each class scores sum(pixels) * 0.5 in 8.18 format.
    function automatic logic [N_CLASSES*RES_W-1:0] half_scores();
        logic [N_CLASSES*RES_W-1:0] r;
        int sum;
        sum = 0;
        for (int k = 0; k < N_PIXELS; k++) sum += int'(Pixels[k*PIX_W +: PIX_W]);
        for (int c = 0; c < N_CLASSES; c++) r[c*RES_W +: RES_W] = RES_W'(sum * (1 << (RES_FRAC - 1)));
        return r;
    endfunction

    // VMP model: garbage while held in reset, real scores exactly COMPUTE_CYCLES after release.
    always @(posedge clk) begin
        if (vmp_start) begin
            vmp_cnt = 0;
            for (int c = 0; c < N_CLASSES; c++) vmp_value[c*RES_W +: RES_W] <= RES_W'($urandom);
        end else if (vmp_cnt < COMPUTE_CYCLES) begin
            vmp_cnt = vmp_cnt + 1;
            if (vmp_cnt == COMPUTE_CYCLES) vmp_value <= half_mode ? half_scores() : model_scores;
        end
    end

    // Reference argmax: signed integers, first strictly-greater wins.
    function automatic void ref_argmax(input logic [N_CLASSES*RES_W-1:0] v,
                                       output logic [ID_W-1:0] id, output logic [RES_W-1:0] sc);
        logic [RES_W-1:0] slice;
        int best;
        int s;
        slice = v[0 +: RES_W];
        best  = int'($signed(slice));
        id    = '0;
        sc    = slice;
        for (int c = 1; c < N_CLASSES; c++) begin
            slice = v[c*RES_W +: RES_W];
            s     = int'($signed(slice));
            if (s > best) begin
                best = s;
                id   = ID_W'(c);
                sc   = slice;
            end
        end
    endfunction

    function automatic logic [RES_W-1:0] fx(input int whole_quarters);
        return RES_W'(whole_quarters * (1 << (RES_FRAC - 2)));
    endfunction

    task automatic fill_image(input bit alternating);
        for (int k = 0; k < N_PIXELS; k++) begin
            img[k] = alternating ? PIX_W'(k % 2) : PIX_W'($urandom);
            exp_pix[k*PIX_W +: PIX_W] = img[k];
        end
    endtask

    task automatic random_scores();
        for (int c = 0; c < N_CLASSES; c++) begin
            if ($urandom_range(0, 1) == 1) model_scores[c*RES_W +: RES_W] = RES_W'($urandom);
            else model_scores[c*RES_W +: RES_W] = fx((int'($urandom_range(0, 6)) - 3) * 4);
        end
    endtask

    // Streams pixels 0..n-1 with pix_last on last_idx; returns the cycle of the final accept.
    task automatic send_frame(input int n, input int last_idx, input bit stall, output int t_last);
        int guard;
        for (int i = 0; i < n; i++) begin
            if (stall) begin
                while ($urandom_range(0, 1) == 0) begin
                    pix_valid = 1'b0;
                    pix_data  = PIX_W'($urandom);
                    @(negedge clk);
                end
            end
            pix_valid = 1'b1;
            pix_data  = img[i];
            pix_last  = (i == last_idx);
            guard = 0;
            while (!pix_ready && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 1000) begin
                $display("FAIL pix_ready_timeout: pixel %0d never accepted", i);
                $fatal(1, "stream stalled");
            end
            @(negedge clk);
        end
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        t_last    = cyc;
    endtask

    task automatic run_inference(input bit stall, input bit hold,
                                 input logic [ID_W-1:0] eid, input logic [RES_W-1:0] esc);
        int t_last;
        int bad;
        send_frame(N_PIXELS, N_PIXELS - 1, stall, t_last);
        checks++;
        if (vmp_start !== 1'b1 || Pixels !== exp_pix) begin
            bad = -1;
            for (int k = N_PIXELS - 1; k >= 0; k--) if (Pixels[k*PIX_W +: PIX_W] !== exp_pix[k*PIX_W +: PIX_W]) bad = k;
            failures++;
            $display("FAIL pixels_at_start: vmp_start=%0b first bad pixel=%0d (-1 none)", vmp_start, bad);
        end
        while (!class_valid && cyc < t_last + LAT + 50) @(negedge clk);
        checks++;
        if (class_valid !== 1'b1 || cyc - t_last != LAT) begin
            failures++;
            $display("FAIL latency: got %0d cycles valid=%0b expected %0d", cyc - t_last, class_valid, LAT);
        end
        checks++;
        if (class_id !== eid) begin
            failures++;
            $display("FAIL class_id: got %0d expected %0d", class_id, eid);
        end
        checks++;
        if (class_score !== esc) begin
            failures++;
            $display("FAIL class_score: got %h expected %h", class_score, esc);
        end
        if (!hold) begin
            class_ready = 1'b1;
            @(negedge clk);
            class_ready = 1'b0;
            checks++;
            if (class_valid !== 1'b0 || pix_ready !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL handshake_idle: valid=%0b ready=%0b busy=%0b expected 0 1 0",
                         class_valid, pix_ready, busy);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (vmp_start !== 1'b1 || pix_ready !== 1'b0 || busy !== 1'b0 || class_valid !== 1'b0 ||
            class_id !== '0 || class_score !== '0 || frame_err !== 1'b0 || Pixels !== '0) begin
            failures++;
            $display("FAIL %s: start=%0b ready=%0b busy=%0b valid=%0b id=%0d score=%h ferr=%0b pixzero=%0b expected 1 0 0 0 0 0 0 1",
                     tag, vmp_start, pix_ready, busy, class_valid, class_id, class_score, frame_err, Pixels == '0);
        end
    endtask

    task automatic test_reset();
        GlobalReset = 1'b1;
        pix_valid   = 1'b0;
        pix_last    = 1'b0;
        pix_data    = '0;
        class_ready = 1'b0;
        half_mode   = 1'b0;
        model_scores = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        GlobalReset = 1'b0;
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1 || vmp_start !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL after_reset: ready=%0b start=%0b busy=%0b expected 1 0 0", pix_ready, vmp_start, busy);
        end
    endtask

    task automatic test_ties();
        half_mode = 1'b1;
        fill_image(1'b1);
        run_inference(1'b0, 1'b0, 4'd0, 26'h3100000);
        half_mode = 1'b0;
    endtask

    task automatic test_distinct();
        fill_image(1'b0);
        for (int c = 0; c < N_CLASSES; c++) model_scores[c*RES_W +: RES_W] = fx(c * 4);
        model_scores[7*RES_W +: RES_W] = fx(-2);
        model_scores[9*RES_W +: RES_W] = fx(400);
        run_inference(1'b0, 1'b0, 4'd9, RES_W'(100 << RES_FRAC));
        // Positive winner against a negative seed: an unsigned compare would keep class 0.
        for (int c = 0; c < N_CLASSES; c++) model_scores[c*RES_W +: RES_W] = fx(-8);
        model_scores[0*RES_W +: RES_W] = fx(-2);
        model_scores[4*RES_W +: RES_W] = fx(12);
        run_inference(1'b0, 1'b0, 4'd4, fx(12));
        // All negative, class 3 at -1.0 is the largest.
        for (int c = 0; c < N_CLASSES; c++) model_scores[c*RES_W +: RES_W] = fx(-4 * (c + 2));
        model_scores[3*RES_W +: RES_W] = fx(-4);
        run_inference(1'b0, 1'b0, 4'd3, fx(-4));
    endtask

    task automatic test_random_stalls();
        logic [ID_W-1:0]  eid;
        logic [RES_W-1:0] esc;
        for (int n = 0; n < 2; n++) begin
            fill_image(1'b0);
            random_scores();
            ref_argmax(model_scores, eid, esc);
            run_inference(1'b1, 1'b0, eid, esc);
        end
    endtask

    task automatic test_framing();
        int t_last;
        logic [ID_W-1:0]  eid;
        logic [RES_W-1:0] esc;
        fill_image(1'b0);
        send_frame(501, 500, 1'b0, t_last);
        checks++;
        if (frame_err !== 1'b1 || pix_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_pulse: ferr=%0b ready=%0b busy=%0b expected 1 1 0", frame_err, pix_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_width: got %0b expected 0", frame_err);
        end
        fill_image(1'b0);
        random_scores();
        ref_argmax(model_scores, eid, esc);
        run_inference(1'b0, 1'b0, eid, esc);
    endtask

    task automatic test_backpressure();
        logic [ID_W-1:0]  eid;
        logic [RES_W-1:0] esc;
        int bad;
        fill_image(1'b0);
        random_scores();
        ref_argmax(model_scores, eid, esc);
        run_inference(1'b0, 1'b1, eid, esc);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (class_valid !== 1'b1 || class_id !== eid || class_score !== esc || pix_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL backpressure_hold: %0d unstable cycles expected 0", bad);
        end
        class_ready = 1'b1;
        @(negedge clk);
        class_ready = 1'b0;
        checks++;
        if (class_valid !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release: valid=%0b busy=%0b ready=%0b expected 0 0 1", class_valid, busy, pix_ready);
        end
    endtask

    task automatic test_reset_in_compute();
        int t_last;
        int seen;
        logic [ID_W-1:0]  eid;
        logic [RES_W-1:0] esc;
        fill_image(1'b0);
        random_scores();
        send_frame(N_PIXELS, N_PIXELS - 1, 1'b0, t_last);
        while (cyc < t_last + START_CYCLES + 100) @(negedge clk);
        GlobalReset = 1'b1;
        #1;
        checks++;
        if (vmp_start !== 1'b1) begin
            failures++;
            $display("FAIL reset_vmp_start: got %0b expected 1", vmp_start);
        end
        @(negedge clk);
        check_reset_outputs("reset_mid_compute");
        GlobalReset = 1'b0;
        seen = 0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            if (class_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_no_result: %0d active cycles expected 0", seen);
        end
        fill_image(1'b0);
        random_scores();
        ref_argmax(model_scores, eid, esc);
        run_inference(1'b1, 1'b0, eid, esc);
    endtask

    initial begin
        test_reset();
        test_ties();
        test_distinct();
        test_random_stalls();
        test_framing();
        test_backpressure();
        test_reset_in_compute();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
